dmem_arbiter: RTL and testbench

//  Shares the single data memory between the pipeline MEM stage and a debug/loader

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_starve_cnt.sv | 36 +++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared types and constants for the data-memory arbiter.
//   dmem_rd_owner_t : identifies who issued the read whose data arrives from
//                     the data memory this cycle (memory read latency is 1).
//   FUNCT3_WORD     : access-size code for a full 32-bit word (debug accesses).
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CORE = 2'd1,
        RD_DBG  = 2'd2
    } dmem_rd_owner_t;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// dmem_starve_cnt
//   Saturating counter of consecutive core grants taken while the debug port
//   was waiting. When it reaches MAX_CORE_RUN the debug port wins the next
//   arbitration.
// Ports
//   clk    in  clock
//   reset  in  synchronous, active-high reset (clears the count)
//   inc    in  core was granted while debug waited
//   clr    in  debug granted, or no debug request pending
//   sat    out count has reached MAX_CORE_RUN
module dmem_starve_cnt #(
    parameter int MAX_CORE_RUN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(MAX_CORE_RUN + 1);
    localparam logic [CW-1:0] MAX_V = CW'(MAX_CORE_RUN);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data memory between the pipeline MEM stage and a
//   debug/loader port. The core has priority; after MAX_CORE_RUN consecutive
//   core grants with debug waiting, debug wins one cycle and the core stalls.
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   core_rd/wr/addr/wdata/funct3  MEM-stage request
//   core_stall                    freeze pipeline this cycle
//   core_rdata                    read data for the core (0 when not returning)
//   dbg_valid/we/addr/wdata       debug request (valid/ready handshake)
//   dbg_ready                     debug request accepted this cycle
//   dbg_rvalid/dbg_rdata          debug read response
//   mem_rd/wr/addr/wdata/funct3   to datamemory
//   mem_rdata                     from datamemory, 1 cycle after mem_rd
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DM_ADDRESS   = 9,
    parameter int DATA_W       = 32,
    parameter int MAX_CORE_RUN = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic                  core_stall,
    output logic [DATA_W-1:0]     core_rdata,
    input  logic                  dbg_valid,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_ready,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    dmem_rd_owner_t rd_owner_q, rd_owner_d;
    logic core_req, gnt_core, gnt_dbg;
    logic starve_inc, starve_clr, starve_sat;

    dmem_starve_cnt #(
        .MAX_CORE_RUN(MAX_CORE_RUN)
    ) u_starve (
        .clk  (clk),
        .reset(reset),
        .inc  (starve_inc),
        .clr  (starve_clr),
        .sat  (starve_sat)
    );

    // Grant, memory mux and read-response routing. Everything is forced to
    // zero during reset so an in-flight read response is dropped.
    always_comb begin
        core_req   = 1'b0;
        gnt_core   = 1'b0;
        gnt_dbg    = 1'b0;
        core_stall = 1'b0;
        dbg_ready  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = '0;
        rd_owner_d = RD_NONE;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        core_rdata = '0;
        if (!reset) begin
            core_req   = core_rd | core_wr;
            gnt_dbg    = dbg_valid & (~core_req | starve_sat);
            gnt_core   = core_req & ~gnt_dbg;
            core_stall = core_req & ~gnt_core;
            dbg_ready  = gnt_dbg;
            starve_inc = gnt_core & dbg_valid;
            starve_clr = gnt_dbg | ~dbg_valid;
            if (gnt_core) begin
                // A simultaneous read+write is a write; it gets no response.
                mem_rd     = core_rd & ~core_wr;
                mem_wr     = core_wr;
                mem_addr   = core_addr;
                mem_wdata  = core_wdata;
                mem_funct3 = core_funct3;
                if (core_rd && !core_wr) rd_owner_d = RD_CORE;
            end else if (gnt_dbg) begin
                mem_rd     = ~dbg_we;
                mem_wr     = dbg_we;
                mem_addr   = dbg_addr;
                mem_wdata  = dbg_wdata;
                mem_funct3 = FUNCT3_WORD;
                if (!dbg_we) rd_owner_d = RD_DBG;
            end
            if (rd_owner_q == RD_DBG) begin
                dbg_rvalid = 1'b1;
                dbg_rdata  = mem_rdata;
            end
            if (rd_owner_q == RD_CORE) begin
                core_rdata = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_q <= RD_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int MAX = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_rd, core_wr;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [2:0]    core_funct3;
    logic          core_stall;
    logic [DW-1:0] core_rdata;
    logic          dbg_valid, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ready, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .MAX_CORE_RUN(MAX)) dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_stall(core_stall), .core_rdata(core_rdata),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    // Data memory device driven by the DUT's memory port (registered read).
    logic [DW-1:0] devmem [512];
    always @(posedge clk) begin
        if (mem_wr) devmem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= devmem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shadow memory, count of core wins while debug waits,
    // and the owner/data of the read issued last cycle.
    logic [DW-1:0] refmem [512];
    int            m_wait  = 0;
    int            m_pend  = 0;  // 0 none, 1 core, 2 debug
    logic [DW-1:0] m_pdata = '0;

    always @(negedge clk) begin
        logic creq, gc, gd, e_rd, e_wr, e_stall, e_rdy, e_rv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_drd, e_crd;
        logic [2:0] e_f3;
        #1;
        creq = 0; gc = 0; gd = 0; e_rd = 0; e_wr = 0; e_stall = 0; e_rdy = 0; e_rv = 0;
        e_addr = '0; e_wd = '0; e_f3 = '0; e_drd = '0; e_crd = '0;
        if (!reset) begin
            creq    = core_rd | core_wr;
            gd      = dbg_valid && (!creq || m_wait == MAX);
            gc      = creq && !gd;
            e_stall = creq && !gc;
            e_rdy   = gd;
            if (gc) begin
                e_rd = core_rd && !core_wr; e_wr = core_wr;
                e_addr = core_addr; e_wd = core_wdata; e_f3 = core_funct3;
            end else if (gd) begin
                e_rd = !dbg_we; e_wr = dbg_we;
                e_addr = dbg_addr; e_wd = dbg_wdata; e_f3 = 3'b010;
            end
            e_rv  = (m_pend == 2);
            e_drd = (m_pend == 2) ? m_pdata : '0;
            e_crd = (m_pend == 1) ? m_pdata : '0;
        end
        chk("core_stall", core_stall, e_stall);
        chk("dbg_ready",  dbg_ready,  e_rdy);
        chk("mem_rd",     mem_rd,     e_rd);
        chk("mem_wr",     mem_wr,     e_wr);
        chk("mem_addr",   mem_addr,   e_addr);
        chk("mem_wdata",  mem_wdata,  e_wd);
        chk("mem_funct3", mem_funct3, e_f3);
        chk("dbg_rvalid", dbg_rvalid, e_rv);
        chk("dbg_rdata",  dbg_rdata,  e_drd);
        chk("core_rdata", core_rdata, e_crd);
        // advance model to the next cycle
        if (reset) begin
            m_wait = 0;
            m_pend = 0;
        end else begin
            m_pend = 0;
            if (e_rd) begin
                m_pend  = gc ? 1 : 2;
                m_pdata = refmem[e_addr];
            end
            if (e_wr) refmem[e_addr] = e_wd;
            if (gd || !dbg_valid) m_wait = 0;
            else if (gc && m_wait < MAX) m_wait = m_wait + 1;
        end
    end

    task automatic drive(input logic crd, input logic cwr, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cwd, input logic [2:0] cf,
                         input logic dv, input logic dwe, input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd, input logic rst);
        @(negedge clk);
        reset = rst;
        core_rd = crd; core_wr = cwr; core_addr = ca; core_wdata = cwd; core_funct3 = cf;
        dbg_valid = dv; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
        #2;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        logic          r_dv, r_we;
        logic [AW-1:0] r_da;
        logic [DW-1:0] r_dwd;
        logic          last_rdy;
        for (int i = 0; i < 512; i++) begin
            devmem[i] = $urandom;
            refmem[i] = devmem[i];
        end
        reset = 1'b1;
        core_rd = 0; core_wr = 0; core_addr = '0; core_wdata = '0; core_funct3 = '0;
        dbg_valid = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;

        // reset state with requests present
        drive(1, 0, 9'h10, '0, 3'b010, 1, 0, 9'h4, '0, 1);
        chk("rst_stall", core_stall, 0);
        chk("rst_ready", dbg_ready, 0);
        chk("rst_memrd", mem_rd, 0);
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, 1);
        idle();

        // debug write 0x20, then core read returns it
        drive(0, 0, '0, '0, '0, 1, 1, 9'h20, 32'hDEADBEEF, 0);
        chk("t2_ready", dbg_ready, 1);
        chk("t2_memwr", mem_wr, 1);
        chk("t2_addr", mem_addr, 32'h20);
        drive(1, 0, 9'h20, '0, 3'b010, 0, 0, '0, '0, 0);
        chk("t2_memrd", mem_rd, 1);
        chk("t2_stall", core_stall, 0);
        idle();
        chk("t2_rdata", core_rdata, 32'hDEADBEEF);

        // core read 0x10 after a known value is placed there
        drive(0, 0, '0, '0, '0, 1, 1, 9'h10, 32'hCAFE0010, 0);
        drive(1, 0, 9'h10, '0, 3'b010, 0, 0, '0, '0, 0);
        chk("t1_memrd", mem_rd, 1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_stall", core_stall, 0);
        idle();
        chk("t1_rdata", core_rdata, 32'hCAFE0010);

        // starvation: 8 core grants, debug wins on the 9th cycle
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 9'h0, '0, 3'b010, 1, 0, 9'h4, '0, 0);
            chk("t3_ready", dbg_ready, (i == 8) ? 1 : 0);
            chk("t3_stall", core_stall, (i == 8) ? 1 : 0);
        end
        idle();

        // back-to-back debug reads
        drive(0, 0, '0, '0, '0, 1, 1, 9'h0, 32'hA0, 0);
        drive(0, 0, '0, '0, '0, 1, 1, 9'h4, 32'hA4, 0);
        drive(0, 0, '0, '0, '0, 1, 1, 9'h8, 32'hA8, 0);
        drive(0, 0, '0, '0, '0, 1, 0, 9'h0, '0, 0);
        drive(0, 0, '0, '0, '0, 1, 0, 9'h4, '0, 0);
        chk("t4_rv0", dbg_rvalid, 1);
        chk("t4_rd0", dbg_rdata, 32'hA0);
        drive(0, 0, '0, '0, '0, 1, 0, 9'h8, '0, 0);
        chk("t4_rd1", dbg_rdata, 32'hA4);
        idle();
        chk("t4_rd2", dbg_rdata, 32'hA8);
        chk("t4_rv2", dbg_rvalid, 1);
        idle();
        chk("t4_rvoff", dbg_rvalid, 0);

        // reset right after a debug read grant drops the response
        drive(0, 0, '0, '0, '0, 1, 0, 9'h4, '0, 0);
        chk("t5_ready", dbg_ready, 1);
        drive(1, 0, 9'h8, '0, 3'b010, 1, 0, 9'h8, '0, 1);
        chk("t5_rvalid", dbg_rvalid, 0);
        chk("t5_rdata", dbg_rdata, 0);
        chk("t5_memrd", mem_rd, 0);
        chk("t5_stall", core_stall, 0);
        idle();

        // core read+write together is a write with no response
        drive(1, 1, 9'h30, 32'h66, 3'b010, 0, 0, '0, '0, 0);
        chk("t6_memwr", mem_wr, 1);
        chk("t6_memrd", mem_rd, 0);
        idle();
        chk("t6_nordata", core_rdata, 0);
        drive(1, 0, 9'h30, '0, 3'b010, 0, 0, '0, '0, 0);
        idle();
        chk("t6_readback", core_rdata, 32'h66);

        // randomized traffic, debug request held until accepted
        r_dv = 0; r_we = 0; r_da = '0; r_dwd = '0; last_rdy = 0;
        for (int n = 0; n < 3000; n++) begin
            logic crd, cwr, rst;
            if (!(r_dv && !last_rdy)) begin
                r_dv  = ($urandom_range(0, 99) < 55);
                r_we  = $urandom_range(0, 1);
                r_da  = AW'($urandom_range(0, 31));
                r_dwd = $urandom;
            end
            crd = ($urandom_range(0, 99) < 60);
            cwr = ($urandom_range(0, 99) < 30);
            rst = ($urandom_range(0, 99) < 2);
            drive(crd, cwr, AW'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 7)),
                  r_dv, r_we, r_da, r_dwd, rst);
            last_rdy = dbg_ready;
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
